// File: rtl/multi_synapse_lif_neuron.sv
// Multi-synapse leaky integrate-and-fire neuron: weighted binary spike inputs,
// multiplicative leak, saturation, threshold/fire/reset and a refractory period.
module multi_synapse_lif_neuron #(
  parameter int WIDTH      = 16,
  parameter int FRACTIONAL = 8,
  parameter int N_INPUTS   = 4,
  parameter int REFRACT_W  = 4,
  parameter int COUNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      step_valid,
  input  logic [N_INPUTS-1:0]       input_spikes,
  input  logic [N_INPUTS*WIDTH-1:0] weights,
  input  logic [WIDTH-1:0]          leak_factor,
  input  logic [WIDTH-1:0]          threshold,
  input  logic [WIDTH-1:0]          reset_value,
  input  logic [REFRACT_W-1:0]      refractory_cycles,
  output logic [WIDTH-1:0]          potential,
  output logic                      spike_out,
  output logic                      refractory_active,
  output logic [COUNT_W-1:0]        spike_count
);

  // Leaked term can exceed WIDTH when leak_factor > 1.0, so the adder is sized
  // to hold both the widest leaked value and the full synaptic sum.
  localparam int PROD_W = 2 * WIDTH + 1;
  localparam int LEAK_W = PROD_W - FRACTIONAL;
  localparam int BASE_W = WIDTH + $clog2(N_INPUTS) + 2;
  localparam int SUM_W  = (LEAK_W + 2 > BASE_W) ? LEAK_W + 2 : BASE_W;

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic [REFRACT_W-1:0]      refr_cnt;
  logic signed [PROD_W-1:0]  product;
  logic signed [PROD_W-1:0]  shifted;
  logic signed [SUM_W-1:0]   leaked;
  logic signed [SUM_W-1:0]   syn;
  logic signed [SUM_W-1:0]   sum;
  logic [WIDTH-1:0]          sat;
  logic                      fire;

  // Zero-extending leak_factor by one bit keeps it unsigned inside a signed multiply.
  assign product = $signed(potential) * $signed({1'b0, leak_factor});
  assign shifted = product >>> FRACTIONAL;
  assign leaked  = SUM_W'(shifted);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    syn = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (input_spikes[i]) begin
        syn = syn + SUM_W'($signed(weights[i*WIDTH +: WIDTH]));
      end
    end
  end

  assign sum = leaked + syn;

  always_comb begin
    sat = sum[WIDTH-1:0];
    if (sum > SAT_MAX) begin
      sat = SAT_MAX[WIDTH-1:0];
    end else if (sum < SAT_MIN) begin
      sat = SAT_MIN[WIDTH-1:0];
    end
  end

  assign fire = $signed(sat) >= $signed(threshold);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      potential         <= '0;
      spike_out         <= 1'b0;
      refr_cnt          <= '0;
      refractory_active <= 1'b0;
      spike_count       <= '0;
    end else begin
      spike_out <= 1'b0;
      if (step_valid) begin
        if (refr_cnt != '0) begin
          refr_cnt          <= refr_cnt - REFRACT_W'(1);
          refractory_active <= (refr_cnt != REFRACT_W'(1));
          potential         <= reset_value;
        end else if (fire) begin
          potential         <= reset_value;
          spike_out         <= 1'b1;
          refr_cnt          <= refractory_cycles;
          refractory_active <= (refractory_cycles != '0);
          if (spike_count != '1) begin
            spike_count <= spike_count + COUNT_W'(1);
          end
        end else begin
          potential <= sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_synapse_lif_neuron.sv
// Directed bench for multi_synapse_lif_neuron with hand-computed expectations.
module tb_multi_synapse_lif_neuron;

  logic        clk = 1'b0;
  logic        rst;
  logic        step_valid;
  logic [3:0]  input_spikes;
  logic [63:0] weights;
  logic [15:0] leak_factor;
  logic [15:0] threshold;
  logic [15:0] reset_value;
  logic [3:0]  refractory_cycles;
  logic [15:0] potential;
  logic        spike_out;
  logic        refractory_active;
  logic [15:0] spike_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multi_synapse_lif_neuron dut (
    .clk               (clk),
    .rst               (rst),
    .step_valid        (step_valid),
    .input_spikes      (input_spikes),
    .weights           (weights),
    .leak_factor       (leak_factor),
    .threshold         (threshold),
    .reset_value       (reset_value),
    .refractory_cycles (refractory_cycles),
    .potential         (potential),
    .spike_out         (spike_out),
    .refractory_active (refractory_active),
    .spike_count       (spike_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_step();
    @(negedge clk);
    step_valid = 1'b1;
    @(posedge clk);
    #1 step_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic set_all_weights(input logic [15:0] w);
    weights = {w, w, w, w};
  endtask

  initial begin
    rst = 1'b1; step_valid = 1'b0; input_spikes = '0; weights = '0;
    leak_factor = 16'h0100; threshold = 16'h7FFF; reset_value = '0;
    refractory_cycles = '0;
    #12;
    check("rst_pot", potential, 0);
    check("rst_spk", spike_out, 0);
    check("rst_ra",  refractory_active, 0);
    check("rst_cnt", spike_count, 0);
    @(negedge clk) rst = 1'b0;

    // Accumulate to fire
    weights = 64'h0000_0000_0000_0100; threshold = 16'h0300;
    reset_value = 16'h0080; input_spikes = 4'b0001;
    do_step(); check("acc_p1", potential, 16'h0100);
    do_step(); check("acc_p2", potential, 16'h0200); check("acc_nospk", spike_out, 0);
    do_step();
    check("acc_spk", spike_out, 1); check("acc_rv", potential, 16'h0080);
    check("acc_cnt", spike_count, 1); check("acc_ra", refractory_active, 0);
    idle_cycle(); check("acc_pulse", spike_out, 0);

    // Refractory period of two steps
    apply_reset(); refractory_cycles = 4'd2;
    do_step(); do_step(); do_step();
    check("ref_spk", spike_out, 1); check("ref_ra0", refractory_active, 1);
    do_step(); check("ref_h1p", potential, 16'h0080); check("ref_h1a", refractory_active, 1);
    check("ref_h1s", spike_out, 0);
    do_step(); check("ref_h2p", potential, 16'h0080); check("ref_h2a", refractory_active, 0);
    do_step(); check("ref_int", potential, 16'h0180); check("ref_ra3", refractory_active, 0);
    check("ref_cnt", spike_count, 1);

    // Leak decay
    apply_reset(); refractory_cycles = '0; threshold = 16'h7FFF;
    weights = 64'h0000_0000_0000_0200; leak_factor = 16'h0100;
    do_step(); check("leak_pre", potential, 16'h0200);
    input_spikes = '0; leak_factor = 16'h0080;
    do_step(); check("leak_1", potential, 16'h0100);
    do_step(); check("leak_2", potential, 16'h0080);
    do_step(); check("leak_3", potential, 16'h0040);

    // Leak rounds toward minus infinity: -3 * 0.5 = -1.5 -> -2
    apply_reset(); weights = 64'h0000_0000_0000_FFFD; leak_factor = 16'h0100;
    input_spikes = 4'b0001;
    do_step(); check("floor_pre", potential, 16'hFFFD);
    input_spikes = '0; leak_factor = 16'h0080;
    do_step(); check("floor_neg", potential, 16'hFFFE);

    // Saturation both ways, fire exactly at threshold
    apply_reset(); leak_factor = 16'h0100; set_all_weights(16'h9000);
    input_spikes = 4'b1111; threshold = 16'h7FFF; reset_value = 16'h0080;
    do_step(); check("sat_neg", potential, 16'h8000); check("sat_neg_spk", spike_out, 0);
    set_all_weights(16'h7000);
    do_step(); check("sat_pos_spk", spike_out, 1); check("sat_pos_rv", potential, 16'h0080);
    check("sat_cnt", spike_count, 1);

    // Mixed excitation and inhibition in one step: 0x80 + 0x300 - 0x100 = 0x280
    weights = {16'h0000, 16'h0000, 16'hFF00, 16'h0300}; input_spikes = 4'b0011;
    do_step(); check("mix", potential, 16'h0280);

    // Step gating
    for (int i = 0; i < 10; i++) begin
      input_spikes = 4'(i);
      idle_cycle();
      check("gate_spk", spike_out, 0);
    end
    check("gate_pot", potential, 16'h0280);
    check("gate_cnt", spike_count, 1);
    check("gate_ra", refractory_active, 0);

    // Async reset mid-operation with refractory counter at 1
    apply_reset(); weights = 64'h0000_0000_0000_0100; threshold = 16'h0100;
    reset_value = 16'h0200; refractory_cycles = 4'd2; input_spikes = 4'b0001;
    do_step(); check("ar_spk", spike_out, 1);
    do_step(); check("ar_pot", potential, 16'h0200); check("ar_ra", refractory_active, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_pot0", potential, 0); check("ar_ra0", refractory_active, 0);
    check("ar_cnt0", spike_count, 0); check("ar_spk0", spike_out, 0);
    @(negedge clk) rst = 1'b0;
    threshold = 16'h7FFF;
    do_step(); check("ar_int", potential, 16'h0100); check("ar_ra1", refractory_active, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got %0d checks, expected completion", n_checks);
    $fatal(1);
  end

endmodule
